// File: rtl/sweep_sequencer.sv
// Sweep sequencer: drives H then V sweep enables, follows counter busy flags,
// tracks the peak-light position and publishes the best H/V pair.
module sweep_sequencer #(
  parameter int POS_W   = 9,
  parameter int LIGHT_W = 10,
  parameter int ARM_MAX = 4,
  parameter int RUN_MAX = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cnt_h,
  input  logic               cnt_v,
  input  logic [LIGHT_W-1:0] light,
  output logic               hs,
  output logic               vs,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [POS_W-1:0]   best_h,
  output logic [POS_W-1:0]   best_v,
  output logic [LIGHT_W-1:0] best_light
);

  localparam int TMAX  = (RUN_MAX > ARM_MAX) ? RUN_MAX : ARM_MAX;
  localparam int TIM_W = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    IDLE,
    H_ARM,
    H_RUN,
    H_GAP,
    V_ARM,
    V_RUN,
    FINISH,
    ERROR
  } state_t;

  state_t             state;
  logic [POS_W-1:0]   pos;
  logic [TIM_W-1:0]   timer;
  logic [LIGHT_W-1:0] wb_light;
  logic [POS_W-1:0]   wb_h;
  logic [POS_W-1:0]   wb_v;

  logic             v_axis;
  logic             axis_busy;
  logic             arm_to;
  logic             run_to;
  logic             peak;
  logic [POS_W-1:0] pos_inc;
  logic [TIM_W-1:0] timer_inc;

  assign v_axis    = (state == V_ARM) || (state == V_RUN);
  assign axis_busy = v_axis ? cnt_v : cnt_h;
  assign arm_to    = timer == TIM_W'(ARM_MAX - 1);
  assign run_to    = timer == TIM_W'(RUN_MAX - 1);
  assign peak      = light > wb_light;
  assign timer_inc = timer + TIM_W'(1);
  // position index holds at all-ones instead of wrapping
  assign pos_inc   = (&pos) ? pos : pos + POS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos        <= '0;
      timer      <= '0;
      wb_light   <= '0;
      wb_h       <= '0;
      wb_v       <= '0;
      hs         <= 1'b0;
      vs         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      best_h     <= '0;
      best_v     <= '0;
      best_light <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        hs    <= 1'b0;
        vs    <= 1'b0;
        busy  <= 1'b0;
        err   <= 1'b0;
      end else begin
        unique case (state)
          IDLE, ERROR: begin
            if (start) begin
              state    <= H_ARM;
              hs       <= 1'b1;
              busy     <= 1'b1;
              err      <= 1'b0;
              pos      <= '0;
              timer    <= '0;
              wb_light <= '0;
              wb_h     <= '0;
              wb_v     <= '0;
            end
          end
          H_ARM, V_ARM: begin
            if (axis_busy) begin
              state <= v_axis ? V_RUN : H_RUN;
              timer <= '0;
            end else if (arm_to) begin
              state <= ERROR;
              hs    <= 1'b0;
              vs    <= 1'b0;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              timer <= timer_inc;
            end
          end
          H_RUN, V_RUN: begin
            if (!axis_busy) begin
              if (v_axis) begin
                state      <= FINISH;
                vs         <= 1'b0;
                done       <= 1'b1;
                best_h     <= wb_h;
                best_v     <= wb_v;
                best_light <= wb_light;
              end else begin
                state <= H_GAP;
                hs    <= 1'b0;
              end
            end else if (run_to) begin
              state <= ERROR;
              hs    <= 1'b0;
              vs    <= 1'b0;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              timer <= timer_inc;
              pos   <= pos_inc;
              // strict compare keeps the earliest position on ties
              if (peak) begin
                wb_light <= light;
                if (v_axis) wb_v <= pos;
                else        wb_h <= pos;
              end
            end
          end
          H_GAP: begin
            state <= V_ARM;
            vs    <= 1'b1;
            pos   <= '0;
            timer <= '0;
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
